speaker_dac_tx: RTL and testbench
=================================

# speaker_dac_tx

Serial transmitter for the audio output path: takes 12-bit unsigned samples, one per sample strobe, from the audio chain on the system clock and shifts each out as a 16-bit SPI-style frame to a DAC121S101-class DAC (Pmod DA2). It is the output-side counterpart of the microphone sample path. It sits between the sample producer and the Pmod pins, with a one-deep holding buffer so that a strobe arriving mid-frame is not lost.

## Interface
Parameters:
- `CLK_DIV`, 4, system-clock cycles per SCLK half-period; legal values are ≥1. The default gives 12.5 MHz SCLK at 100 MHz.
- `PD_MODE`, 2'b00, DAC power-down bits sent in every frame.

Ports:
- `clk` in 1: system clock (100 MHz). One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `sample_in` in 12: unsigned sample. Captured in any cycle where `sample_valid`=1.
- `sample_valid` in 1: single-cycle strobe, nominally at 20 kHz.
- `dac_sync` out 1: active-low frame select.
- `dac_sclk` out 1: serial clock. Idles high.
- `dac_d` out 1: serial data, MSB first.
- `busy` out 1: high when the FSM is not in IDLE, or when a sample is pending.
- `overflow_cnt` out 8: dropped-sample count. Present only with `DAC_OVF_CNT_EN`.

## Operation
- Frame is 16 bits: {2'b00, PD_MODE, sample[11:0]}, MSB first.
- FSM states:
  - IDLE: `dac_sync`=1, `dac_sclk`=1, `dac_d`=0.
  - LOAD: single cycle.
  - SHIFT: serialises the frame.
  - GAP: inter-frame quiet time.
- IDLE → LOAD when `sample_valid`=1 or `pend_v`=1.
  - If both are set, `sample_in` is used, the pending sample is discarded and counted as an overflow.
  - Otherwise the pending sample is used and `pend_v` is cleared.
- LOAD:
  - Shift register is loaded.
  - `dac_sync`←0 and `dac_d`←bit15; `dac_sclk` stays 1.
  - Bit counter is set to 0, then the FSM moves to SHIFT.
- SHIFT: a divider counts `CLK_DIV` cycles per half-period.
  - End of a high phase: `dac_sclk`←0. This is the DAC sample edge.
  - End of a low phase: `dac_sclk`←1, and the bit counter increments.
  - If the counter is below 16 after incrementing, `dac_d` advances to the next bit.
  - After the 16th low phase ends: `dac_sclk`←1, `dac_sync`←1, `dac_d`←0, and the FSM moves to GAP.
- GAP: holds `dac_sync`=1 for 2·`CLK_DIV` cycles, then returns to IDLE.
- Holding buffer (`pend_v`, `pend_data`):
  - A `sample_valid` in LOAD, SHIFT or GAP stores `sample_in` into `pend_data` and sets `pend_v`.
  - If `pend_v` is already 1, the new sample overwrites the old one (newest wins) and it counts as an overflow.
- Overflow counter: 8-bit, saturates at 255, cleared only by reset.
- Arithmetic: the bit counter is 5 bits. The divider is `$clog2(CLK_DIV+1)` bits and resets to 0 at every phase edge.

## Timing
- Reset values: `dac_sync`=1, `dac_sclk`=1, `dac_d`=0, `busy`=0, `overflow_cnt`=0, `pend_v`=0, FSM=IDLE.
- Reset asserted mid-frame returns every output to its reset value on the next edge. The partial frame is aborted (SYNC rises early, which the DAC ignores).
- Latency from a `sample_valid` in IDLE: `dac_sync` falls 1 cycle later.
- Frame length: 1 + 32·`CLK_DIV` + 2·`CLK_DIV` cycles, from the start of LOAD to the start of IDLE. With defaults this is 137 cycles (1.37 µs), well inside the 50 µs sample period.
- `dac_d` changes only on a rising SCLK edge (or in LOAD). It is stable for `CLK_DIV` cycles on each side of every falling edge.
- A pending sample in IDLE starts its frame on the first IDLE cycle. There are no extra idle cycles between back-to-back frames beyond GAP.
- `busy` is combinational from the state and `pend_v`, and is registered with them.

## Configuration
- `DAC_OVF_CNT_EN` defined: the `overflow_cnt` port and the saturating counter are present.
- Not defined: the port and counter are omitted. Overwrite behaviour is unchanged, and drops are silent.

## Test plan
- Reset, then `sample_valid` with `sample_in`=12'hA5C (default parameters):
  - `dac_sync` falls 1 cycle later.
  - 16 falling SCLK edges sample 0000_1010_0101_1100.
  - `dac_sync` rises, and IDLE is reached 137 cycles after LOAD.
- `PD_MODE`=2'b11, `sample_in`=12'h000: bits sampled are 0011_0000_0000_0000.
- Second strobe (12'h123) 20 cycles into a frame of 12'hFFF:
  - `busy` stays 1.
  - The second frame starts on the first IDLE cycle and carries 12'h123.
  - `overflow_cnt`=0.
- Three strobes (12'h111, 12'h222, 12'h333) within one frame:
  - The next frame carries 12'h333.
  - `overflow_cnt`=1 with `DAC_OVF_CNT_EN`.
- `reset` at bit 7 of a frame: the next cycle shows `dac_sync`=1, `dac_sclk`=1, `dac_d`=0, `busy`=0, pending cleared.
- `CLK_DIV`=1, strobe every 50 cycles with an incrementing sample:
  - Every frame is 35 cycles and every value is transmitted.
  - `overflow_cnt` stays 0 over 1000 frames.

Source files
------------

// File: rtl/speaker_dac_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : speaker_dac_tx                                               |
// | Description : Serialises 12-bit audio samples into 16-bit SPI-style frames |
// |               for a DAC121S101-class DAC, with a one-deep holding buffer.  |
// |               Optional macro DAC_OVF_CNT_EN adds the overflow_cnt port and |
// |               its saturating dropped-sample counter.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module speaker_dac_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [1:0] PD_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_d,
  output logic        busy
`ifdef DAC_OVF_CNT_EN
  ,
  output logic [7:0]  overflow_cnt
`endif
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state, state_n;
  logic [15:0]       shreg, shreg_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [4:0]        bitcnt, bitcnt_n;
  logic [4:0]        bitcnt_inc;
  logic              gap_half, gap_half_n;
  logic              sync_q, sync_n;
  logic              sclk_q, sclk_n;
  logic              pend_v, pend_v_n;
  logic [11:0]       pend_data, pend_data_n;

  assign bitcnt_inc = bitcnt + 5'd1;

  // The shift register fills with zeros as it empties, so its MSB is the
  // serial data line and naturally reads 0 outside a frame.
  assign dac_d    = shreg[15];
  assign dac_sync = sync_q;
  assign dac_sclk = sclk_q;
  assign busy     = (state != IDLE) || pend_v;

  // Next-state, serial timing and holding-buffer logic
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    div_n       = div;
    bitcnt_n    = bitcnt;
    gap_half_n  = gap_half;
    sync_n      = sync_q;
    sclk_n      = sclk_q;
    pend_v_n    = pend_v;
    pend_data_n = pend_data;

    case (state)
      IDLE: begin
        if (sample_valid || pend_v) begin
          // A fresh strobe beats a pending sample; the pending one is dropped.
          shreg_n  = {2'b00, PD_MODE, (sample_valid ? sample_in : pend_data)};
          pend_v_n = 1'b0;
          sync_n   = 1'b0;
          sclk_n   = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        bitcnt_n = 5'd0;
        div_n    = '0;
        state_n  = SHIFT;
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (sclk_q) begin
            sclk_n = 1'b0;
          end else begin
            // Rising edge: data advances here so it is stable around the fall.
            sclk_n   = 1'b1;
            bitcnt_n = bitcnt_inc;
            shreg_n  = {shreg[14:0], 1'b0};
            if (bitcnt_inc == 5'd16) begin
              sync_n     = 1'b1;
              gap_half_n = 1'b0;
              state_n    = GAP;
            end
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      GAP: begin
        // Two divider periods of quiet, reusing the half-period divider.
        if (div == DIV_LAST) begin
          div_n = '0;
          if (gap_half) begin
            state_n = IDLE;
          end else begin
            gap_half_n = 1'b1;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Strobes arriving mid-frame park in the buffer; newest always wins.
    if (sample_valid && (state != IDLE)) begin
      pend_v_n    = 1'b1;
      pend_data_n = sample_in;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      div       <= '0;
      bitcnt    <= '0;
      gap_half  <= 1'b0;
      sync_q    <= 1'b1;
      sclk_q    <= 1'b1;
      pend_v    <= 1'b0;
      pend_data <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      div       <= div_n;
      bitcnt    <= bitcnt_n;
      gap_half  <= gap_half_n;
      sync_q    <= sync_n;
      sclk_q    <= sclk_n;
      pend_v    <= pend_v_n;
      pend_data <= pend_data_n;
    end
  end

`ifdef DAC_OVF_CNT_EN
  // Saturating count of samples lost to an occupied holding buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (sample_valid && pend_v && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_speaker_dac_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_speaker_dac_tx                                            |
// | Description : Directed self-checking bench for speaker_dac_tx. Instance A  |
// |               uses default parameters, instance B uses CLK_DIV=1 and       |
// |               PD_MODE=2'b11. Honours DAC_OVF_CNT_EN when defined.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_speaker_dac_tx;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] smp_a, smp_b;
  logic        val_a, val_b;
  logic        sync_a, sclk_a, d_a, busy_a;
  logic        sync_b, sclk_b, d_b, busy_b;
`ifdef DAC_OVF_CNT_EN
  logic [7:0]  ovf_a, ovf_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  speaker_dac_tx dut_a (
    .clk          (clk),
    .reset        (rst_a),
    .sample_in    (smp_a),
    .sample_valid (val_a),
    .dac_sync     (sync_a),
    .dac_sclk     (sclk_a),
    .dac_d        (d_a),
    .busy         (busy_a)
`ifdef DAC_OVF_CNT_EN
    ,
    .overflow_cnt (ovf_a)
`endif
  );

  speaker_dac_tx #(.CLK_DIV(1), .PD_MODE(2'b11)) dut_b (
    .clk          (clk),
    .reset        (rst_b),
    .sample_in    (smp_b),
    .sample_valid (val_b),
    .dac_sync     (sync_b),
    .dac_sclk     (sclk_b),
    .dac_d        (d_b),
    .busy         (busy_b)
`ifdef DAC_OVF_CNT_EN
    ,
    .overflow_cnt (ovf_b)
`endif
  );

  // DAC-side receivers: shift dac_d on each falling SCLK while SYNC is low,
  // record the word and the SYNC-low length when SYNC rises.
  logic [15:0] rxw_a = '0, rxw_b = '0;
  int          low_a = 0, low_b = 0;
  logic        ps_a = 1'b1, pk_a = 1'b1, ps_b = 1'b1, pk_b = 1'b1;
  logic [15:0] words_a[$], words_b[$];
  int          lows_a[$], lows_b[$];

  always @(negedge clk) begin
    if (ps_a && !sync_a) begin
      rxw_a <= '0;
      low_a <= 1;
    end else if (!sync_a) begin
      low_a <= low_a + 1;
    end
    if (!sync_a && pk_a && !sclk_a) rxw_a <= {rxw_a[14:0], d_a};
    if (!ps_a && sync_a) begin
      words_a.push_back(rxw_a);
      lows_a.push_back(low_a);
    end
    ps_a <= sync_a;
    pk_a <= sclk_a;
  end

  always @(negedge clk) begin
    if (ps_b && !sync_b) begin
      rxw_b <= '0;
      low_b <= 1;
    end else if (!sync_b) begin
      low_b <= low_b + 1;
    end
    if (!sync_b && pk_b && !sclk_b) rxw_b <= {rxw_b[14:0], d_b};
    if (!ps_b && sync_b) begin
      words_b.push_back(rxw_b);
      lows_b.push_back(low_b);
    end
    ps_b <= sync_b;
    pk_b <= sclk_b;
  end

  function automatic logic [15:0] wa(int i);
    if (i >= 0 && i < words_a.size()) return words_a[i];
    return 'x;
  endfunction
  function automatic logic [15:0] wb(int i);
    if (i >= 0 && i < words_b.size()) return words_b[i];
    return 'x;
  endfunction
  function automatic int la(int i);
    if (i >= 0 && i < lows_a.size()) return lows_a[i];
    return -1;
  endfunction
  function automatic int lb(int i);
    if (i >= 0 && i < lows_b.size()) return lows_b[i];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int n, nw, cnt;
  logic [11:0] kv;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    val_a = 1'b0; val_b = 1'b0;
    smp_a = '0;   smp_b = '0;
    repeat (3) step();

    // Reset state
    check("rst_sync", 32'(sync_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_d",    32'(d_a),    32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
`ifdef DAC_OVF_CNT_EN
    check("rst_ovf", 32'(ovf_a), 32'd0);
`endif
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Single frame of 12'hA5C with default parameters
    nw = words_a.size();
    smp_a = 12'hA5C; val_a = 1'b1;
    step();
    val_a = 1'b0;
    check("t1_sync_latency", 32'(sync_a), 32'd0);
    check("t1_sclk_load",    32'(sclk_a), 32'd1);
    check("t1_d_load",       32'(d_a),    32'd0);
    check("t1_busy",         32'(busy_a), 32'd1);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!busy_a) break;
      n++;
    end
    check("t1_frame_len", 32'(n), 32'd137);
    check("t1_nframes",   32'(words_a.size()), 32'(nw + 1));
    check("t1_word",      32'(wa(nw)), 32'h0A5C);
    check("t1_sync_low",  32'(la(nw)), 32'd129);
    check("t1_idle_sync", 32'(sync_a), 32'd1);
    check("t1_idle_sclk", 32'(sclk_a), 32'd1);

    // PD_MODE=2'b11 with a zero sample on instance B
    nw = words_b.size();
    smp_b = 12'h000; val_b = 1'b1;
    step();
    val_b = 1'b0;
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!busy_b) break;
      n++;
    end
    check("t2_frame_len", 32'(n), 32'd35);
    check("t2_word",      32'(wb(nw)), 32'h3000);
    check("t2_sync_low",  32'(lb(nw)), 32'd33);

    // Second strobe 20 cycles into a frame: buffered, sent back to back
    nw = words_a.size();
    smp_a = 12'hFFF; val_a = 1'b1;
    step();
    val_a = 1'b0;
    n = 1;
    for (int i = 0; i < 600; i++) begin
      if (n == 20) begin smp_a = 12'h123; val_a = 1'b1; end
      else val_a = 1'b0;
      step();
      if (!busy_a) break;
      n++;
    end
    val_a = 1'b0;
    check("t3_busy_span", 32'(n), 32'd275);
    check("t3_nframes",   32'(words_a.size()), 32'(nw + 2));
    check("t3_word0",     32'(wa(nw)),     32'h0FFF);
    check("t3_word1",     32'(wa(nw + 1)), 32'h0123);
`ifdef DAC_OVF_CNT_EN
    check("t3_ovf", 32'(ovf_a), 32'd0);
`endif

    // Three strobes in one frame: the newest pending sample wins
    nw = words_a.size();
    smp_a = 12'h111; val_a = 1'b1;
    step();
    val_a = 1'b0;
    n = 1;
    for (int i = 0; i < 600; i++) begin
      if (n == 20)      begin smp_a = 12'h222; val_a = 1'b1; end
      else if (n == 60) begin smp_a = 12'h333; val_a = 1'b1; end
      else val_a = 1'b0;
      step();
      if (!busy_a) break;
      n++;
    end
    val_a = 1'b0;
    check("t4_busy_span", 32'(n), 32'd275);
    check("t4_nframes",   32'(words_a.size()), 32'(nw + 2));
    check("t4_word0",     32'(wa(nw)),     32'h0111);
    check("t4_word1",     32'(wa(nw + 1)), 32'h0333);
`ifdef DAC_OVF_CNT_EN
    check("t4_ovf", 32'(ovf_a), 32'd1);
`endif

    // Reset during bit 7 with a sample pending
    smp_a = 12'h5A5; val_a = 1'b1;
    step();
    val_a = 1'b0;
    for (int i = 0; i < 59; i++) begin
      if (i == 29) begin smp_a = 12'h777; val_a = 1'b1; end
      else val_a = 1'b0;
      step();
    end
    val_a = 1'b0;
    check("t5_mid_frame_sync", 32'(sync_a), 32'd0);
    rst_a = 1'b1;
    step();
    check("t5_rst_sync", 32'(sync_a), 32'd1);
    check("t5_rst_sclk", 32'(sclk_a), 32'd1);
    check("t5_rst_d",    32'(d_a),    32'd0);
    check("t5_rst_busy", 32'(busy_a), 32'd0);
`ifdef DAC_OVF_CNT_EN
    check("t5_rst_ovf", 32'(ovf_a), 32'd0);
`endif
    rst_a = 1'b0;
    repeat (3) step();
    check("t5_pend_cleared", 32'(busy_a), 32'd0);
    check("t5_sync_idle",    32'(sync_a), 32'd1);

    // CLK_DIV=1 streaming: strobe every 50 cycles, incrementing samples
    for (int k = 0; k < 1000; k++) begin
      kv = k[11:0];
      nw = words_b.size();
      smp_b = kv; val_b = 1'b1;
      step();
      val_b = 1'b0;
      cnt = 1;
      for (int j = 1; j < 50; j++) begin
        step();
        if (busy_b) cnt++;
      end
      check("t6_frame_len", 32'(cnt), 32'd35);
      check("t6_word",      32'(wb(nw)), 32'({4'b0011, kv}));
    end
`ifdef DAC_OVF_CNT_EN
    check("t6_ovf", 32'(ovf_b), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
